// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   PORT_CORE / PORT_DMA : port identifiers (also the grant-vector bit index)
//   acc_reg_t            : access-stage register {valid, port, we, addr, wdata}
//   STARVE_W             : width of the starvation counter for the default limit
package dmem_arb_pkg;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  localparam int ACC_ADDR_W       = 32;
  localparam int ACC_DATA_W       = 32;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int STARVE_W         = $clog2(STARVE_LIMIT_DEF + 1);

  typedef struct packed {
    logic                  valid;
    logic                  port;
    logic                  we;
    logic [ACC_ADDR_W-1:0] addr;
    logic [ACC_DATA_W-1:0] wdata;
  } acc_reg_t;

endpackage

// File: rtl/dmem_arb_prio.sv
// Fixed-priority grant (port 0 wins) with a starvation guard for port 1.
// Ports:
//   clk_pi, reset_pi : clock, async active-high reset
//   req0_pi, req1_pi : requests from core (0) and DMA (1)
//   gnt_po[1:0]      : one-hot (or zero) grant, combinational
module dmem_arb_prio
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic       clk_pi,
  input  logic       reset_pi,
  input  logic       req0_pi,
  input  logic       req1_pi,
  output logic [1:0] gnt_po
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;

  // Grants are suppressed while reset is asserted so nothing is accepted.
  always_comb begin
    gnt_po = '0;
    if (!reset_pi) begin
      if (req0_pi && !(req1_pi && (starve_cnt == LIMIT)))
        gnt_po[PORT_CORE] = 1'b1;
      else if (req1_pi)
        gnt_po[PORT_DMA] = 1'b1;
    end
  end

  // Counts port-0 wins while port 1 is waiting; any gap in req1 restarts it.
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (!req1_pi || gnt_po[PORT_DMA])
      starve_cnt_nxt = '0;
    else if (gnt_po[PORT_CORE] && (starve_cnt != LIMIT))
      starve_cnt_nxt = starve_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk_pi or posedge reset_pi) begin
    if (reset_pi) starve_cnt <= '0;
    else          starve_cnt <= starve_cnt_nxt;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port 32x32 data memory.
// Pipeline: accept (gnt) in T, memory access in T+1, load response in T+2.
// Ports:
//   clk_pi, reset_pi                     : clock, async active-high reset
//   reqN/weN/addrN/wdataN_pi (N=0,1)     : request and qualifiers, held until gntN_po
//   gntN_po                              : request accepted this cycle
//   rvalidN_po, rdataN_po                : load response pulse / held load data
//   mem_load/store/addr/wdata_po         : memory drive from the access register
//   mem_rdata_pi                         : combinational memory read data
// The access register width comes from the package, so ADDR_W/DATA_W must
// track ACC_ADDR_W/ACC_DATA_W.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = ACC_ADDR_W,
  parameter int DATA_W       = ACC_DATA_W,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk_pi,
  input  logic              reset_pi,
  input  logic              req0_pi,
  input  logic              we0_pi,
  input  logic [ADDR_W-1:0] addr0_pi,
  input  logic [DATA_W-1:0] wdata0_pi,
  input  logic              req1_pi,
  input  logic              we1_pi,
  input  logic [ADDR_W-1:0] addr1_pi,
  input  logic [DATA_W-1:0] wdata1_pi,
  output logic              gnt0_po,
  output logic              gnt1_po,
  output logic              rvalid0_po,
  output logic [DATA_W-1:0] rdata0_po,
  output logic              rvalid1_po,
  output logic [DATA_W-1:0] rdata1_po,
  output logic              mem_load_po,
  output logic              mem_store_po,
  output logic [ADDR_W-1:0] mem_addr_po,
  output logic [DATA_W-1:0] mem_wdata_po,
  input  logic [DATA_W-1:0] mem_rdata_pi
);

  logic [1:0] gnt;
  acc_reg_t   acc_q;

  dmem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk_pi   (clk_pi),
    .reset_pi (reset_pi),
    .req0_pi  (req0_pi),
    .req1_pi  (req1_pi),
    .gnt_po   (gnt)
  );

  assign gnt0_po = gnt[PORT_CORE];
  assign gnt1_po = gnt[PORT_DMA];

  // Address/data only load on an accepted request so they hold through idle cycles.
  always_ff @(posedge clk_pi or posedge reset_pi) begin
    if (reset_pi) begin
      acc_q <= '0;
    end else begin
      acc_q.valid <= |gnt;
      if (|gnt) begin
        acc_q.port  <= gnt[PORT_DMA];
        acc_q.we    <= gnt[PORT_DMA] ? we1_pi    : we0_pi;
        acc_q.addr  <= gnt[PORT_DMA] ? addr1_pi  : addr0_pi;
        acc_q.wdata <= gnt[PORT_DMA] ? wdata1_pi : wdata0_pi;
      end
    end
  end

  assign mem_store_po = acc_q.valid &  acc_q.we;
  assign mem_load_po  = acc_q.valid & ~acc_q.we;
  assign mem_addr_po  = acc_q.addr;
  assign mem_wdata_po = acc_q.wdata;

  always_ff @(posedge clk_pi or posedge reset_pi) begin
    if (reset_pi) begin
      rvalid0_po <= 1'b0;
      rvalid1_po <= 1'b0;
      rdata0_po  <= '0;
      rdata1_po  <= '0;
    end else begin
      rvalid0_po <= mem_load_po && (acc_q.port == PORT_CORE);
      rvalid1_po <= mem_load_po && (acc_q.port == PORT_DMA);
      if (mem_load_po && (acc_q.port == PORT_CORE)) rdata0_po <= mem_rdata_pi;
      if (mem_load_po && (acc_q.port == PORT_DMA))  rdata1_po <= mem_rdata_pi;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter with a transaction-level
// reference: grants from the priority/starvation rule, memory contents
// updated in acceptance order, responses scheduled two cycles after accept.
module tb_dmem_arbiter;

  localparam int LIMIT = 4;

  logic        clk_pi = 1'b0;
  logic        reset_pi;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, gnt1, rv0, rv1;
  logic [31:0] rd0, rd1;
  logic        mem_load, mem_store;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_fill;
  logic [31:0] tb_mem [32];

  always #5 clk_pi = ~clk_pi;

  always @(posedge clk_pi) begin
    if (mem_fill) begin
      for (int i = 0; i < 32; i++) tb_mem[i] <= 32'(100 + i);
    end else if (mem_store) begin
      tb_mem[mem_addr[4:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = tb_mem[mem_addr[4:0]];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk_pi       (clk_pi),
    .reset_pi     (reset_pi),
    .req0_pi      (req0),
    .we0_pi       (we0),
    .addr0_pi     (addr0),
    .wdata0_pi    (wdata0),
    .req1_pi      (req1),
    .we1_pi       (we1),
    .addr1_pi     (addr1),
    .wdata1_pi    (wdata1),
    .gnt0_po      (gnt0),
    .gnt1_po      (gnt1),
    .rvalid0_po   (rv0),
    .rdata0_po    (rd0),
    .rvalid1_po   (rv1),
    .rdata1_po    (rd1),
    .mem_load_po  (mem_load),
    .mem_store_po (mem_store),
    .mem_addr_po  (mem_addr),
    .mem_wdata_po (mem_wdata),
    .mem_rdata_pi (mem_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [31:0] ref_mem [32];
  int          wait_cnt, cur_wait, max_wait;
  logic        a_v, a_port, a_we;
  logic [31:0] a_addr, a_wdata, a_ld, a_undo;
  logic        e_rv0, e_rv1;
  logic [31:0] e_rd0, e_rd1;
  logic        g0, g1, o_g1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic gen(input int pct, output logic r, output logic w,
                     output logic [31:0] a, output logic [31:0] d);
    r = ($urandom_range(99) < pct);
    w = 1'($urandom_range(1));
    a = $urandom;
    d = $urandom;
  endtask

  // One clock cycle: check at negedge, advance the model, return at posedge+1.
  task automatic step();
    logic eg0, eg1;
    @(negedge clk_pi);
    eg0 = req0 && !(req1 && (wait_cnt >= LIMIT));
    eg1 = req1 && !eg0;
    chk("gnt0", gnt0, eg0);
    chk("gnt1", gnt1, eg1);
    chk("mem_load", mem_load, a_v && !a_we);
    chk("mem_store", mem_store, a_v && a_we);
    chk("mem_addr", mem_addr, a_addr);
    chk("mem_wdata", mem_wdata, a_wdata);
    chk("rvalid0", rv0, e_rv0);
    chk("rvalid1", rv1, e_rv1);
    chk("rdata0", rd0, e_rd0);
    chk("rdata1", rd1, e_rd1);
    o_g1 = gnt1;

    if (req1 && !eg1) cur_wait++;
    else              cur_wait = 0;
    if (cur_wait > max_wait) max_wait = cur_wait;

    e_rv0 = a_v && !a_we && (a_port == 1'b0);
    e_rv1 = a_v && !a_we && (a_port == 1'b1);
    if (e_rv0) e_rd0 = a_ld;
    if (e_rv1) e_rd1 = a_ld;

    a_v = eg0 || eg1;
    if (a_v) begin
      a_port  = eg1;
      a_we    = eg1 ? we1 : we0;
      a_addr  = eg1 ? addr1 : addr0;
      a_wdata = eg1 ? wdata1 : wdata0;
      if (a_we) begin
        a_undo = ref_mem[a_addr[4:0]];
        ref_mem[a_addr[4:0]] = a_wdata;
      end else begin
        a_ld = ref_mem[a_addr[4:0]];
      end
    end

    if (!req1 || eg1) wait_cnt = 0;
    else if (eg0)     wait_cnt++;
    g0 = eg0;
    g1 = eg1;
    @(posedge clk_pi);
    #1;
  endtask

  // Reset asserted in the middle of a cycle: outputs must drop at once.
  task automatic reset_mid();
    #1 reset_pi = 1'b1;
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_mem_load", mem_load, 0);
    chk("rst_mem_store", mem_store, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rvalid0", rv0, 0);
    chk("rst_rvalid1", rv1, 0);
    chk("rst_rdata0", rd0, 0);
    chk("rst_rdata1", rd1, 0);
    if (a_v && a_we) ref_mem[a_addr[4:0]] = a_undo;
    a_v = 0; a_we = 0; a_port = 0; a_addr = '0; a_wdata = '0;
    e_rv0 = 0; e_rv1 = 0; e_rd0 = '0; e_rd1 = '0;
    wait_cnt = 0; cur_wait = 0;
    repeat (2) @(posedge clk_pi);
    #1 reset_pi = 1'b0;
  endtask

  initial begin
    logic [9:0] seq3;
    logic [4:0] seq5;
    int         pcts [4] = '{100, 70, 30, 10};

    reset_pi = 1'b1;
    mem_fill = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'(100 + i);
    wait_cnt = 0; cur_wait = 0; max_wait = 0;
    a_v = 0; a_port = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_ld = '0; a_undo = '0;
    e_rv0 = 0; e_rv1 = 0; e_rd0 = '0; e_rd1 = '0;
    g0 = 0; g1 = 0; o_g1 = 0;

    repeat (3) @(posedge clk_pi);
    #1 mem_fill = 1'b0;

    // reset state, with a core load already requesting
    req0 = 1; we0 = 0; addr0 = 32'd3;
    #1;
    chk("rst0_gnt0", gnt0, 0);
    chk("rst0_mem_load", mem_load, 0);
    chk("rst0_mem_store", mem_store, 0);
    chk("rst0_mem_addr", mem_addr, 0);
    chk("rst0_rvalid0", rv0, 0);
    chk("rst0_rvalid1", rv1, 0);
    chk("rst0_rdata0", rd0, 0);
    @(posedge clk_pi);
    #1 reset_pi = 1'b0;
    step();
    chk("t1_gnt0_after_release", o_g1 == 1'b0 && g0, 1);
    req0 = 0;
    repeat (3) step();
    chk("t1_rdata0", rd0, 32'd103);

    // DMA load of addr 7 from the initial image
    req1 = 1; we1 = 0; addr1 = 32'd7; wdata1 = 32'h1234;
    step();
    req1 = 0;
    repeat (3) step();
    chk("t4_rdata1", rd1, 32'd107);

    // core store then load of the same word
    req0 = 1; we0 = 1; addr0 = 32'd5; wdata0 = 32'hDEAD;
    step();
    we0 = 0; wdata0 = 32'h0;
    step();
    req0 = 0;
    repeat (3) step();
    chk("t2_rdata0", rd0, 32'hDEAD);

    // continuous contention: port 1 forced every fifth grant
    req0 = 1; we0 = 0; addr0 = 32'd1;
    req1 = 1; we1 = 0; addr1 = 32'd2;
    for (int i = 0; i < 10; i++) begin
      step();
      seq3[i] = o_g1;
    end
    chk("t3_grant_seq", 32'(seq3), 32'h210);

    // req1 gap restarts the starvation count
    repeat (3) step();
    req1 = 0;
    step();
    req1 = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      seq5[i] = o_g1;
    end
    chk("t5_grant_seq", 32'(seq5), 32'h10);
    req0 = 0; req1 = 0;
    repeat (3) step();

    // randomized traffic at several loads, with mid-run resets
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 350; c++) begin
        if ((p == 1 || p == 2) && c == 175) reset_mid();
        step();
        if (g0 || !req0) gen(pcts[p], req0, we0, addr0, wdata0);
        if (g1 || !req1) gen(pcts[p], req1, we1, addr1, wdata1);
      end
    end

    req0 = 0; req1 = 0;
    repeat (4) step();
    for (int i = 0; i < 32; i++) chk("mem_image", tb_mem[i], ref_mem[i]);
    chk("p1_max_wait_bound", 32'(max_wait <= LIMIT), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
